// File: rtl/pwm_pkg.sv
// Types and constants shared by the PWM generator and capture blocks.
package pwm_pkg;

  localparam int unsigned CntWDefault = 16;

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StMeas
  } state_e;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer with rising-edge detect on the synchronized level.
module sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o,
  output logic rise_o
);

  localparam int unsigned FillW = $clog2(SYNC_STAGES + 2);
  localparam logic [FillW-1:0] FillMax = FillW'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [FillW-1:0]       fill_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      fill_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
      if (fill_q != FillMax) begin
        fill_q <= fill_q + FillW'(1);
      end
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];
  // The reset zeros in the pipe are not a real low level; an input already
  // high at reset release must not look like a rising edge.
  assign rise_o = q_o & ~prev_q & (fill_q == FillMax);

endmodule

// File: rtl/pwm_capture.sv
// Measures period and high time of an asynchronous PWM input, with a
// valid/ready result port, stuck-input timeout and sticky overrun flag.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W       = CntWDefault,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             pwm_i,
  output logic             meas_valid_o,
  input  logic             meas_ready_i,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic             stuck_o,
  output logic             stuck_level_o,
  output logic             overrun_o
);

  localparam logic [CNT_W-1:0] CntMax  = '1;
  localparam logic [CNT_W-1:0] CntOne  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CntLast = {{(CNT_W-1){1'b1}}, 1'b0};

  logic level, rise;

  sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk   (clk),
    .rst   (rst),
    .d_i   (pwm_i),
    .q_o   (level),
    .rise_o(rise)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             stuck_q, stuck_d;
  logic             stuck_lvl_q, stuck_lvl_d;
  logic             overrun_q, overrun_d;

  logic             new_res;
  logic [CNT_W-1:0] res_per, res_hi;
  logic             res_stuck, res_lvl;

  always_comb begin
    state_d   = state_q;
    per_cnt_d = per_cnt_q;
    hi_cnt_d  = hi_cnt_q;
    new_res   = 1'b0;
    res_per   = '0;
    res_hi    = '0;
    res_stuck = 1'b0;
    res_lvl   = 1'b0;

    unique case (state_q)
      StIdle: begin
        per_cnt_d = '0;
        hi_cnt_d  = '0;
        if (en_i) state_d = StArm;
      end
      StArm, StMeas: begin
        if (rise) begin
          // Result is the count before the edge; the edge cycle opens the next period.
          new_res   = (state_q == StMeas);
          res_per   = per_cnt_q;
          res_hi    = hi_cnt_q;
          per_cnt_d = CntOne;
          hi_cnt_d  = CntOne;
          state_d   = StMeas;
        end else if (per_cnt_q == CntLast) begin
          new_res   = 1'b1;
          res_per   = CntMax;
          res_hi    = level ? CntMax : '0;
          res_stuck = 1'b1;
          res_lvl   = level;
          per_cnt_d = '0;
          hi_cnt_d  = '0;
          state_d   = StArm;
        end else begin
          per_cnt_d = per_cnt_q + CntOne;
          if (state_q == StMeas && level) hi_cnt_d = hi_cnt_q + CntOne;
        end
      end
      default: state_d = StIdle;
    endcase

    if (!en_i) begin
      state_d   = StIdle;
      per_cnt_d = '0;
      hi_cnt_d  = '0;
      new_res   = 1'b0;
    end
  end

  always_comb begin
    valid_d     = valid_q;
    period_d    = period_q;
    high_d      = high_q;
    stuck_d     = stuck_q;
    stuck_lvl_d = stuck_lvl_q;
    overrun_d   = overrun_q;

    if (new_res && (!valid_q || meas_ready_i)) begin
      valid_d     = 1'b1;
      period_d    = res_per;
      high_d      = res_hi;
      stuck_d     = res_stuck;
      stuck_lvl_d = res_lvl;
    end else if (new_res) begin
      overrun_d = 1'b1;
    end else if (valid_q && meas_ready_i) begin
      valid_d = 1'b0;
    end

    if (!en_i) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      per_cnt_q   <= '0;
      hi_cnt_q    <= '0;
      valid_q     <= 1'b0;
      period_q    <= '0;
      high_q      <= '0;
      stuck_q     <= 1'b0;
      stuck_lvl_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      per_cnt_q   <= per_cnt_d;
      hi_cnt_q    <= hi_cnt_d;
      valid_q     <= valid_d;
      period_q    <= period_d;
      high_q      <= high_d;
      stuck_q     <= stuck_d;
      stuck_lvl_q <= stuck_lvl_d;
      overrun_q   <= overrun_d;
    end
  end

  assign meas_valid_o  = valid_q;
  assign period_o      = period_q;
  assign high_o        = high_q;
  assign stuck_o       = stuck_q;
  assign stuck_level_o = stuck_lvl_q;
  assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: periodic waveforms, timeouts, backpressure,
// enable drop and asynchronous reset.
module tb_pwm_capture;

  localparam int unsigned CntW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            en_i;
  logic            pwm_i;
  logic            meas_valid_o;
  logic            meas_ready_i;
  logic [CntW-1:0] period_o;
  logic [CntW-1:0] high_o;
  logic            stuck_o;
  logic            stuck_level_o;
  logic            overrun_o;

  int checks = 0;
  int errors = 0;
  int gen_hi = 0;
  int gen_lo = 0;
  bit gen_on = 1'b0;
  int n;

  pwm_capture #(
    .CNT_W      (CntW),
    .SYNC_STAGES(2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en_i         (en_i),
    .pwm_i        (pwm_i),
    .meas_valid_o (meas_valid_o),
    .meas_ready_i (meas_ready_i),
    .period_o     (period_o),
    .high_o       (high_o),
    .stuck_o      (stuck_o),
    .stuck_level_o(stuck_level_o),
    .overrun_o    (overrun_o)
  );

  always #5 clk = ~clk;

  // Waveform source: gen_hi cycles high then gen_lo cycles low, repeating.
  initial begin : pwm_gen
    int ph;
    ph    = 0;
    pwm_i = 1'b0;
    forever begin
      @(negedge clk);
      if (!gen_on) begin
        pwm_i = 1'b0;
        ph    = 0;
      end else begin
        pwm_i = (ph < gen_hi);
        ph    = (ph + 1 >= gen_hi + gen_lo) ? 0 : ph + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int budget, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!meas_valid_o && cyc < budget);
    checks++;
    assert (meas_valid_o === 1'b1) else begin
      errors++;
      $error("FAIL wait_valid: no result within %0d cycles, valid observed %b expected 1",
             budget, meas_valid_o);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, meas_valid_o, 0);
    check({tag, "_period"}, period_o, 0);
    check({tag, "_high"}, high_o, 0);
    check({tag, "_stuck"}, stuck_o, 0);
    check({tag, "_level"}, stuck_level_o, 0);
    check({tag, "_overrun"}, overrun_o, 0);
  endtask

  initial begin
    rst          = 1'b1;
    en_i         = 1'b0;
    meas_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // 3 high / 5 low, always ready
    gen_hi = 3; gen_lo = 5; gen_on = 1'b1;
    meas_ready_i = 1'b1;
    en_i = 1'b1;
    wait_valid(60, n);
    check("p35_period", period_o, 8);
    check("p35_high", high_o, 3);
    check("p35_stuck", stuck_o, 0);
    check("p35_overrun", overrun_o, 0);
    wait_valid(20, n);
    check("p35_interval", n, 8);
    check("p35_period2", period_o, 8);
    check("p35_high2", high_o, 3);

    // input held low: timeout every 255 ARM cycles
    en_i = 1'b0; gen_on = 1'b0;
    repeat (4) @(negedge clk);
    en_i = 1'b1;
    wait_valid(300, n);
    check("lo_latency", n, 256);
    check("lo_period", period_o, 255);
    check("lo_high", high_o, 0);
    check("lo_stuck", stuck_o, 1);
    check("lo_level", stuck_level_o, 0);
    wait_valid(300, n);
    check("lo_interval", n, 255);
    check("lo_stuck2", stuck_o, 1);

    // input held high from before enable: timeout with level 1
    en_i = 1'b0;
    gen_hi = 1; gen_lo = 0; gen_on = 1'b1;
    repeat (6) @(negedge clk);
    en_i = 1'b1;
    wait_valid(300, n);
    check("hi_latency", n, 256);
    check("hi_period", period_o, 255);
    check("hi_high", high_o, 255);
    check("hi_stuck", stuck_o, 1);
    check("hi_level", stuck_level_o, 1);

    // 2/2 with consumer stalled: hold, overrun, then one-cycle transfer
    en_i = 1'b0; meas_ready_i = 1'b0;
    gen_hi = 2; gen_lo = 2;
    repeat (3) @(negedge clk);
    en_i = 1'b1;
    wait_valid(40, n);
    check("bp_period", period_o, 4);
    check("bp_high", high_o, 2);
    check("bp_stuck", stuck_o, 0);
    check("bp_overrun0", overrun_o, 0);
    repeat (5) @(negedge clk);
    check("bp_overrun1", overrun_o, 1);
    check("bp_hold_valid", meas_valid_o, 1);
    check("bp_hold_period", period_o, 4);
    check("bp_hold_high", high_o, 2);
    meas_ready_i = 1'b1;
    @(negedge clk);
    meas_ready_i = 1'b0;
    check("bp_xfer_valid", meas_valid_o, 0);
    check("bp_xfer_overrun", overrun_o, 1);
    repeat (3) @(negedge clk);
    check("bp_reload_valid", meas_valid_o, 1);

    // enable drop clears valid and overrun; restart gives an exact period
    en_i = 1'b0;
    @(negedge clk);
    check("en_valid", meas_valid_o, 0);
    check("en_overrun", overrun_o, 0);
    en_i = 1'b1;
    wait_valid(40, n);
    check("en_period", period_o, 4);
    check("en_high", high_o, 2);
    check("en_overrun2", overrun_o, 0);

    // completion on the same cycle as a transfer
    repeat (3) @(negedge clk);
    meas_ready_i = 1'b1;
    @(negedge clk);
    meas_ready_i = 1'b0;
    check("same_valid", meas_valid_o, 1);
    check("same_overrun", overrun_o, 0);
    check("same_period", period_o, 4);

    // asynchronous reset at a random point of a 3/5 waveform
    gen_hi = 3; gen_lo = 5;
    meas_ready_i = 1'b1;
    repeat ($urandom_range(3, 10)) @(negedge clk);
    rst = 1'b1;
    #1;
    check_all_zero("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    wait_valid(60, n);
    check("rst_latency_gt8", (n > 8) ? 1 : 0, 1);
    check("rst_period", period_o, 8);
    check("rst_high", high_o, 3);
    check("rst_stuck", stuck_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 Parameter CNT_W, default 16, SHALL set the width of the period and high-time counters and result outputs.
REQ-002 Parameter SYNC_STAGES, default 2, min 2, SHALL set the synchronizer depth on pwm_i.
REQ-003 clk  input  1  sole clock; all flops rising-edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 en_i  input  1  capture enable; low forces IDLE.
REQ-006 pwm_i  input  1  asynchronous PWM waveform under measurement.
REQ-007 meas_valid_o  output  1  result available.
REQ-008 meas_ready_i  input  1  consumer accepts result.
REQ-009 period_o  output  CNT_W  clk cycles between consecutive rising edges.
REQ-010 high_o  output  CNT_W  cycles within that period with the synchronized input high.
REQ-011 stuck_o  output  1  result is a timeout (no rising edge), not a full period.
REQ-012 stuck_level_o  output  1  synchronized level during the timeout.
REQ-013 overrun_o  output  1  sticky: a completed result was dropped.

Function
REQ-014 pwm_i SHALL pass through SYNC_STAGES flops; rising edge = synced high and previous synced sample low.
REQ-015 States SHALL be IDLE, ARM, MEAS.
REQ-016 IDLE -> ARM when en_i=1; any state -> IDLE within one cycle of en_i=0, clearing counters, meas_valid_o and overrun_o.
REQ-017 ARM: ignores levels until first rising edge, then -> MEAS with period count and high count both starting at 1 for the edge cycle.
REQ-018 MEAS: each cycle period count +1; high count +1 when synced level is 1.
REQ-019 On a rising edge in MEAS the counts accumulated before that edge SHALL become the result; counters restart at 1/1 on the same cycle, no cycle lost.
REQ-020 The result SHALL satisfy high_o <= period_o; the edge cycle counts as high in the new period.
REQ-021 meas_valid_o SHALL assert on the cycle after the edge is detected (SYNC_STAGES+1 clk cycles after a pwm_i edge that meets setup).
REQ-022 Timeout: in ARM or MEAS, when the period count reaches 2^CNT_W-1 with no rising edge, emit result period_o=all-ones, high_o=all-ones if synced level 1 else 0, stuck_o=1, stuck_level_o=level; then -> ARM.
REQ-023 Result transfer SHALL occur on a cycle with meas_valid_o=1 and meas_ready_i=1; outputs hold stable while valid and not ready.
REQ-024 New result while valid and not ready: new result dropped, held result unchanged, overrun_o set until en_i=0 or rst.
REQ-025 New result on the same cycle as a transfer: new result loaded, meas_valid_o stays 1, no overrun.
REQ-026 stuck_o/stuck_level_o SHALL be 0 for normal results.

Reset
REQ-027 rst SHALL force state IDLE, synchronizer and edge flops 0, counters 0, meas_valid_o=0, period_o=0, high_o=0, stuck_o=0, stuck_level_o=0, overrun_o=0.
REQ-028 Reset asserted mid-measurement SHALL discard partial counts; after release, measurement restarts from ARM (en_i permitting).

Structure
REQ-029 Shared package pwm_pkg SHALL hold the state enum type and the default CNT_W constant, common with the PWM generator.
REQ-030 Synchronizer plus edge detect SHALL be a sub-module sync_edge (ports clk, rst, d_i, q_o, rise_o).

Verification
REQ-031 pwm_i high 3 / low 5 cycles, repeating, ready=1 -> after first full period, results period_o=8, high_o=3, stuck_o=0 every 8 cycles.
REQ-032 pwm_i held low, CNT_W=8 -> first result after 255 cycles in ARM: period_o=255, high_o=0, stuck_o=1, stuck_level_o=0; repeats.
REQ-033 pwm_i 2-high/2-low, ready=0 -> first result held stable (4,2), overrun_o=1 on next period; ready=1 for one cycle -> transfer, overrun_o stays 1.
REQ-034 Result completion on same cycle as ready=1 transfer -> new result present next cycle, overrun_o=0.
REQ-035 rst pulsed mid-period (random phase) -> all outputs 0 immediately; next valid result only after two rising edges post-release, with correct period_o.
REQ-036 en_i dropped mid-period then raised -> meas_valid_o=0, overrun_o=0, first new result period_o exact (no partial count).
